// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mips_pkg
// Brief   : Opcodes, select encodings and state encoding for the multicycle
//           MIPS main control FSM.
// Revision: 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] S_FETCH   = 4'd0;
    localparam logic [STATE_W-1:0] S_DECODE  = 4'd1;
    localparam logic [STATE_W-1:0] S_MEMADR  = 4'd2;
    localparam logic [STATE_W-1:0] S_MEMRD   = 4'd3;
    localparam logic [STATE_W-1:0] S_MEMWB   = 4'd4;
    localparam logic [STATE_W-1:0] S_MEMWR   = 4'd5;
    localparam logic [STATE_W-1:0] S_EXECUTE = 4'd6;
    localparam logic [STATE_W-1:0] S_ALUWB   = 4'd7;
    localparam logic [STATE_W-1:0] S_BRANCH  = 4'd8;
    localparam logic [STATE_W-1:0] S_ADDIEX  = 4'd9;
    localparam logic [STATE_W-1:0] S_ADDIWB  = 4'd10;
    localparam logic [STATE_W-1:0] S_JUMP    = 4'd11;

endpackage
`default_nettype wire

// File: rtl/mips_mc_control.sv
`default_nettype none
// ============================================================================
// Module  : mips_mc_control
// Brief   : Multicycle MIPS main control FSM with memory handshake, retired
//           instruction counter and sticky illegal-opcode flag.
// Revision: 1.0 - initial release
// ============================================================================
module mips_mc_control
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       op_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             mem_req_o,
    output logic             i_or_d_o,
    output logic             mem_write_o,
    output logic             ir_write_o,
    output logic             reg_dst_o,
    output logic             mem_to_reg_o,
    output logic             reg_write_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [1:0]       Alu_op_o,
    output logic [1:0]       pc_src_o,
    output logic             pc_en_o,
    output logic             illegal_op_o,
    output logic [CNT_W-1:0] instr_count_o
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic               illegal_q;
    logic [CNT_W-1:0]   count_q;

    logic       w_retire;
    logic       w_illegal;
    logic       w_mem_req;
    logic       w_i_or_d;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_dst;
    logic       w_mem_to_reg;
    logic       w_reg_write;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic [1:0] w_pc_src;
    logic       w_pc_write;
    logic       w_branch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            if (w_illegal) begin
                illegal_q <= 1'b1;
            end
            if (w_retire) begin
                count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // w_retire marks every return to FETCH that completes a legal instruction.
    always_comb begin
        state_d   = state_q;
        w_retire  = 1'b0;
        w_illegal = 1'b0;
        case (state_q)
            S_FETCH:   if (mem_ready_i) state_d = S_DECODE;
            S_DECODE: begin
                case (op_i)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR:  state_d = (op_i == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (mem_ready_i) state_d = S_MEMWB;
            S_MEMWR: begin
                if (mem_ready_i) begin
                    state_d  = S_FETCH;
                    w_retire = 1'b1;
                end
            end
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
                state_d  = S_FETCH;
                w_retire = 1'b1;
            end
            default:   state_d = S_FETCH;
        endcase
    end

    // Outputs are held at zero for the whole time reset is asserted.
    always_comb begin
        w_mem_req    = 1'b0;
        w_i_or_d     = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_write  = 1'b0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = SRCB_REG;
        w_alu_op     = ALU_ADD;
        w_pc_src     = PC_ALU;
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    w_mem_req   = 1'b1;
                    w_alu_src_b = SRCB_FOUR;
                    w_ir_write  = mem_ready_i;
                    w_pc_write  = mem_ready_i;
                end
                S_DECODE:  w_alu_src_b = SRCB_IMM_SH2;
                S_MEMADR, S_ADDIEX: begin
                    w_alu_src_a = 1'b1;
                    w_alu_src_b = SRCB_IMM;
                end
                S_MEMRD: begin
                    w_mem_req = 1'b1;
                    w_i_or_d  = 1'b1;
                end
                S_MEMWB: begin
                    w_reg_write  = 1'b1;
                    w_mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    w_mem_req   = 1'b1;
                    w_i_or_d    = 1'b1;
                    w_mem_write = 1'b1;
                end
                S_EXECUTE: begin
                    w_alu_src_a = 1'b1;
                    w_alu_op    = ALU_FUNCT;
                end
                S_ALUWB: begin
                    w_reg_write = 1'b1;
                    w_reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    w_alu_src_a = 1'b1;
                    w_alu_op    = ALU_SUB;
                    w_pc_src    = PC_ALUOUT;
                    w_branch    = 1'b1;
                end
                S_ADDIWB:  w_reg_write = 1'b1;
                S_JUMP: begin
                    w_pc_src   = PC_JUMP;
                    w_pc_write = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mem_req_o     = w_mem_req;
    assign i_or_d_o      = w_i_or_d;
    assign mem_write_o   = w_mem_write;
    assign ir_write_o    = w_ir_write;
    assign reg_dst_o     = w_reg_dst;
    assign mem_to_reg_o  = w_mem_to_reg;
    assign reg_write_o   = w_reg_write;
    assign alu_src_a_o   = w_alu_src_a;
    assign alu_src_b_o   = w_alu_src_b;
    assign Alu_op_o      = w_alu_op;
    assign pc_src_o      = w_pc_src;
    assign pc_en_o       = w_pc_write | (w_branch & zero_i);
    assign illegal_op_o  = illegal_q;
    assign instr_count_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_mc_control.sv
`default_nettype none
// ============================================================================
// Module  : tb_mips_mc_control
// Brief   : Self-checking bench: opcode table, corner-case sequences and random
//           instruction streams against an instruction-level microcode model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mips_mc_control;
    import mips_pkg::*;

    localparam int CNT_W = 4;

    typedef struct packed {
        logic       mem_req;
        logic       i_or_d;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_en;
    } outs_t;

    typedef struct packed {
        logic  ready;
        outs_t o;
    } step_t;

    typedef struct {
        logic [5:0] op;
        logic       z;
        int         cycles;
        int         retire;
        logic       ill;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic [5:0]       op_i;
    logic             zero_i;
    logic             mem_ready_i;
    logic             mem_req_o, i_or_d_o, mem_write_o, ir_write_o;
    logic             reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o;
    logic [1:0]       alu_src_b_o, Alu_op_o, pc_src_o;
    logic             pc_en_o, illegal_op_o;
    logic [CNT_W-1:0] instr_count_o;
    outs_t            w_act;

    int         total = 0;
    int         bad   = 0;
    logic [3:0] m_cnt;
    logic       m_ill;
    step_t      q[$];
    vec_t       tbl[8];

    mips_mc_control #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op_i         (op_i),
        .zero_i       (zero_i),
        .mem_ready_i  (mem_ready_i),
        .mem_req_o    (mem_req_o),
        .i_or_d_o     (i_or_d_o),
        .mem_write_o  (mem_write_o),
        .ir_write_o   (ir_write_o),
        .reg_dst_o    (reg_dst_o),
        .mem_to_reg_o (mem_to_reg_o),
        .reg_write_o  (reg_write_o),
        .alu_src_a_o  (alu_src_a_o),
        .alu_src_b_o  (alu_src_b_o),
        .Alu_op_o     (Alu_op_o),
        .pc_src_o     (pc_src_o),
        .pc_en_o      (pc_en_o),
        .illegal_op_o (illegal_op_o),
        .instr_count_o(instr_count_o)
    );

    assign w_act = {mem_req_o, i_or_d_o, mem_write_o, ir_write_o, reg_dst_o,
                    mem_to_reg_o, reg_write_o, alu_src_a_o, alu_src_b_o,
                    Alu_op_o, pc_src_o, pc_en_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic outs_t fetch_outs(input logic ready);
        outs_t o;
        o           = '0;
        o.mem_req   = 1'b1;
        o.alu_src_b = 2'b01;
        o.ir_write  = ready;
        o.pc_en     = ready;
        return o;
    endfunction

    task automatic push(input logic ready, input outs_t o);
        step_t s;
        s.ready = ready;
        s.o     = o;
        q.push_back(s);
    endtask

    // Microcode of one whole instruction: per-cycle mem_ready and expected outputs.
    task automatic build(input logic [5:0] op, input logic z, input int wf,
                         input int wm, output int retire);
        outs_t o;
        q.delete();
        retire = 1;
        for (int i = 0; i < wf; i++) push(1'b0, fetch_outs(1'b0));
        push(1'b1, fetch_outs(1'b1));
        o = '0; o.alu_src_b = 2'b11;
        push(1'($urandom), o);
        case (op)
            OP_LW, OP_SW: begin
                o = '0; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
                push(1'($urandom), o);
                o = '0; o.mem_req = 1'b1; o.i_or_d = 1'b1; o.mem_write = (op == OP_SW);
                for (int i = 0; i < wm; i++) push(1'b0, o);
                push(1'b1, o);
                if (op == OP_LW) begin
                    o = '0; o.reg_write = 1'b1; o.mem_to_reg = 1'b1;
                    push(1'($urandom), o);
                end
            end
            OP_RTYPE: begin
                o = '0; o.alu_src_a = 1'b1; o.alu_op = 2'b10;
                push(1'($urandom), o);
                o = '0; o.reg_write = 1'b1; o.reg_dst = 1'b1;
                push(1'($urandom), o);
            end
            OP_BEQ: begin
                o = '0; o.alu_src_a = 1'b1; o.alu_op = 2'b01; o.pc_src = 2'b01; o.pc_en = z;
                push(1'($urandom), o);
            end
            OP_ADDI: begin
                o = '0; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
                push(1'($urandom), o);
                o = '0; o.reg_write = 1'b1;
                push(1'($urandom), o);
            end
            OP_J: begin
                o = '0; o.pc_src = 2'b10; o.pc_en = 1'b1;
                push(1'($urandom), o);
            end
            default: retire = 0;
        endcase
    endtask

    // Starts and ends 1 time unit after a rising edge with the DUT in FETCH.
    task automatic run_instr(input logic [5:0] op, input logic z, input int wf, input int wm);
        int    retire;
        step_t s;
        build(op, z, wf, wm, retire);
        op_i   = op;
        zero_i = z;
        while (q.size() > 0) begin
            s = q.pop_front();
            mem_ready_i = s.ready;
            @(negedge clk);
            check("outs", 32'(w_act), 32'(s.o));
            check("instr_count", 32'(instr_count_o), 32'(m_cnt));
            check("illegal_op", 32'(illegal_op_o), 32'(m_ill));
            @(posedge clk);
            #1;
        end
        if (retire != 0) m_cnt = m_cnt + 4'd1;
        else             m_ill = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int   n;
        logic done;
        op_i        = v.op;
        zero_i      = v.z;
        mem_ready_i = 1'b1;
        n           = 0;
        done        = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 20 && !done; k++) begin
            @(posedge clk);
            #1;
            n++;
            @(negedge clk);
            if (ir_write_o) done = 1'b1;
        end
        check("vec_returned_to_fetch", 32'(done), 32'd1);
        mem_ready_i = 1'b0;
        @(posedge clk);
        #1;
        m_cnt = m_cnt + 4'(v.retire);
        m_ill = m_ill | v.ill;
        check("vec_cycles", 32'(n), 32'(v.cycles));
        check("vec_count", 32'(instr_count_o), 32'(m_cnt));
        check("vec_illegal", 32'(illegal_op_o), 32'(m_ill));
    endtask

    initial begin
        logic [5:0] ops[6];
        logic [5:0] rop;
        ops[0] = OP_RTYPE; ops[1] = OP_LW;   ops[2] = OP_SW;
        ops[3] = OP_BEQ;   ops[4] = OP_ADDI; ops[5] = OP_J;

        tbl[0] = '{OP_RTYPE, 1'b0, 4, 1, 1'b0};
        tbl[1] = '{OP_LW,    1'b0, 5, 1, 1'b0};
        tbl[2] = '{OP_SW,    1'b1, 4, 1, 1'b0};
        tbl[3] = '{OP_BEQ,   1'b1, 3, 1, 1'b0};
        tbl[4] = '{OP_BEQ,   1'b0, 3, 1, 1'b0};
        tbl[5] = '{OP_ADDI,  1'b0, 4, 1, 1'b0};
        tbl[6] = '{OP_J,     1'b0, 3, 1, 1'b0};
        tbl[7] = '{6'b111111, 1'b0, 2, 0, 1'b1};

        rst_n       = 1'b0;
        op_i        = '0;
        zero_i      = 1'b0;
        mem_ready_i = 1'b0;
        m_cnt       = '0;
        m_ill       = 1'b0;
        #1;
        check("reset_outs", 32'(w_act), 32'd0);
        check("reset_count", 32'(instr_count_o), 32'd0);
        check("reset_illegal", 32'(illegal_op_o), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("fetch_after_reset", 32'(w_act), 32'(fetch_outs(1'b0)));
        @(posedge clk);
        #1;

        foreach (tbl[i]) run_vec(tbl[i]);

        // Illegal flag must stay set through following legal instructions.
        run_instr(OP_J, 1'b0, 0, 0);
        run_instr(OP_BEQ, 1'b1, 1, 0);
        run_instr(OP_BEQ, 1'b0, 0, 0);
        run_instr(OP_RTYPE, 1'b0, 0, 0);
        run_instr(OP_LW, 1'b0, 0, 3);

        // Asynchronous reset in the middle of a stalled data read.
        op_i        = OP_LW;
        mem_ready_i = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        mem_ready_i = 1'b0;
        @(negedge clk);
        check("memrd_req", 32'({mem_req_o, i_or_d_o}), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outs", 32'(w_act), 32'd0);
        check("async_reset_count", 32'(instr_count_o), 32'd0);
        check("async_reset_illegal", 32'(illegal_op_o), 32'd0);
        m_cnt = '0;
        m_ill = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("fetch_after_async_reset", 32'(w_act), 32'(fetch_outs(1'b0)));
        @(posedge clk);
        #1;

        // Counter wraps modulo 16.
        repeat (17) run_instr(OP_ADDI, 1'($urandom), 0, 0);
        check("wrap_count", 32'(instr_count_o), 32'd1);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                rop = 6'($urandom);
                foreach (ops[k]) if (rop == ops[k]) rop = 6'b111111;
            end else begin
                rop = ops[$urandom_range(0, 5)];
            end
            run_instr(rop, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Multicycle MIPS main control FSM. It is the initiator side of the ALU control interface: it drives Alu_op, which the ALU block decodes together with funct.
- Sequences fetch, decode, execute, memory and writeback for the core's datapath from the opcode and the ALU zero flag.
- Handshakes with instruction/data memory through mem_req/mem_ready.
- Counts retired instructions and flags unsupported opcodes.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  6  opcode, instr[31:26], from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access requested.
- i_or_d  out  1  address source: 0 = PC, 1 = ALUOut.
- mem_write  out  1  data memory write.
- ir_write  out  1  load the instruction register.
- reg_dst  out  1  write register: 0 = rt, 1 = rd.
- mem_to_reg  out  1  writeback source: 0 = ALUOut, 1 = MDR.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A: 0 = PC, 1 = reg A.
- alu_src_b  out  2  ALU B: 00 = reg B, 01 = 4, 10 = signext imm, 11 = signext imm<<2.
- Alu_op  out  2  ALU mode: 00 = add, 01 = sub, 10 = use funct.
- pc_src  out  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- pc_en  out  1  PC load enable.
- illegal_op  out  1  sticky flag for an unsupported opcode.
- instr_count  out  CNT_W  retired-instruction count.

Behaviour:
- Reset: rst_n low asynchronously sets state = FETCH, instr_count = 0 and illegal_op = 0. While rst_n is low, all outputs are forced to 0 combinationally.
- Moore decode: every output except pc_en is a function of the state only. Any output not listed for a state is 0.
- pc_en = pc_write | (branch & zero). pc_write and branch are internal signals.
- FETCH:
  - Outputs: mem_req = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, Alu_op = 00, pc_src = 00.
  - ir_write = mem_ready and pc_write = mem_ready.
  - Stays in FETCH until mem_ready = 1, then goes to DECODE.
- DECODE:
  - Outputs: alu_src_a = 0, alu_src_b = 11, Alu_op = 00 (precomputes the branch target).
  - Next state by op: 100011 (lw) or 101011 (sw) -> MEMADR; 000000 (R-type) -> EXECUTE; 000100 (beq) -> BRANCH; 001000 (addi) -> ADDIEX; 000010 (j) -> JUMP.
  - Any other op: set illegal_op, go to FETCH, do not increment instr_count.
- MEMADR: alu_src_a = 1, alu_src_b = 10, Alu_op = 00. Goes to MEMRD if op = lw, else MEMWR.
- MEMRD: mem_req = 1, i_or_d = 1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: reg_write = 1, mem_to_reg = 1, reg_dst = 0. Goes to FETCH.
- MEMWR: mem_req = 1, i_or_d = 1, mem_write = 1. Holds until mem_ready, then goes to FETCH.
- EXECUTE: alu_src_a = 1, alu_src_b = 00, Alu_op = 10. Goes to ALUWB.
- ALUWB: reg_write = 1, reg_dst = 1, mem_to_reg = 0. Goes to FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, Alu_op = 01, pc_src = 01, branch = 1. Goes to FETCH.
- ADDIEX: alu_src_a = 1, alu_src_b = 10, Alu_op = 00. Goes to ADDIWB.
- ADDIWB: reg_write = 1, reg_dst = 0, mem_to_reg = 0. Goes to FETCH.
- JUMP: pc_src = 10, pc_write = 1. Goes to FETCH.
- instr_count: increments by 1 on every transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP. It wraps modulo 2^CNT_W.
- Cycle counts with mem_ready tied to 1: R-type 4, lw 5, sw 4, beq 3, addi 4, j 3.
- Memory wait states: in FETCH, MEMRD and MEMWR, mem_req and all address/ALU selects stay stable while mem_ready is low. ir_write and pc_en remain 0 during the wait.
- mem_ready outside FETCH, MEMRD and MEMWR is ignored.
- Unused state encodings go to FETCH.

Decomposition:
- Package mips_pkg holds:
  - the opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - the Alu_op encodings ALU_ADD, ALU_SUB, ALU_FUNCT;
  - the alu_src_b and pc_src select encodings;
  - the state encoding, 4-bit binary.
- The block is a single module (state register, next-state logic, output decode, counter). No sub-module.

Test Plan:
- Reset: rst_n = 0 mid-MEMRD -> all outputs 0 immediately, instr_count = 0. After release: FETCH with mem_req = 1.
- R-type, op = 000000, mem_ready = 1 -> states FETCH, DECODE, EXECUTE, ALUWB. Alu_op = 10 in EXECUTE, reg_write = 1 and reg_dst = 1 in ALUWB, instr_count = 1.
- lw, op = 100011, mem_ready held low 3 cycles in MEMRD -> mem_req = 1 and i_or_d = 1 for 4 cycles, then MEMWB with mem_to_reg = 1. Total 8 cycles.
- beq, op = 000100: with zero = 1 -> pc_en = 1, pc_src = 01, Alu_op = 01. With zero = 0 -> pc_en = 0. instr_count increments in both cases.
- Illegal opcode, op = 111111 -> DECODE then FETCH, illegal_op = 1 and sticky, instr_count unchanged. Next a j (op = 000010) -> pc_src = 10, pc_en = 1.
- Counter wrap with CNT_W = 4: 17 addi instructions -> instr_count = 1.
